instruction_fetch_unit: RTL
===========================

// Module: instruction_fetch_unit
// PURPOSE
//  Upstream fetch stage of the 16-bit CPU. Owns the program counter (PC) and the
//  instruction register (IR), reads instructions from instruction memory over a
//  req/valid handshake, and hands each latched IR to the control unit. The control
//  unit drives FETCH, PC_CLR and PC_LD; this block reports FETCH_DONE / FETCH_ERR.
// PARAMETERS
//  PC_W     7   PC / instruction-memory address width (128 words)
//  INSTR_W  16  instruction width
//  TIMEOUT  15  max cycles I_REQ stays high without I_VALID before abort (>=1)
// PORTS
//  Clock       in   1        single clock, all state on rising edge
//  Reset       in   1        synchronous, active-low
//  FETCH       in   1        start fetch at current PC; honoured only in IDLE
//  PC_CLR      in   1        PC <= 0; aborts any fetch in progress
//  PC_LD       in   1        relative branch; honoured only in IDLE
//  BR_OFF      in   8        signed branch offset (two's complement)
//  I_RDATA     in   INSTR_W  instruction-memory read data
//  I_VALID     in   1        I_RDATA valid; sampled only while I_REQ=1
//  I_ADDR      out  PC_W     instruction-memory address (registered)
//  I_REQ       out  1        read request (registered), held until valid/abort
//  PC          out  PC_W     current program counter
//  IR          out  INSTR_W  instruction register
//  BUSY        out  1        1 in WAIT or DONE
//  FETCH_DONE  out  1        1-cycle pulse: new IR valid
//  FETCH_ERR   out  1        1-cycle pulse: timeout abort
// BEHAVIOUR
//  Reset (Reset=0 at edge): PC=0, IR=0, I_ADDR=0, I_REQ=0, FETCH_DONE=0,
//   FETCH_ERR=0, timeout counter=0, state=IDLE. Overrides all other inputs.
//  States: IDLE, WAIT, DONE.
//  IDLE: FETCH=1 -> I_ADDR<=PC, I_REQ<=1, cnt<=0, ->WAIT.
//   PC_LD=1 -> PC <= PC + sext(BR_OFF), truncated to PC_W bits (wraps both ways).
//   FETCH and PC_LD same cycle: PC_LD wins, FETCH dropped (CU re-issues).
//  WAIT: I_REQ=1, I_ADDR held. I_VALID=1 -> IR<=I_RDATA, PC<=PC+1 (wraps
//   2^PC_W-1 -> 0), I_REQ<=0, ->DONE. Else cnt++; on TIMEOUT-th cycle without
//   I_VALID -> I_REQ<=0, FETCH_ERR<=1, ->IDLE; PC, IR unchanged.
//   I_VALID on the TIMEOUT-th cycle is still accepted (valid beats timeout).
//  DONE: FETCH_DONE=1 for exactly this cycle, ->IDLE.
//  Latency: FETCH sampled edge 0 -> I_REQ=1 from edge 1; I_VALID first sampled
//   edge 2 at earliest; FETCH_DONE=1 the cycle after the I_VALID edge
//   (min 3 cycles FETCH->FETCH_DONE).
//  PC_CLR (any state, priority below Reset, above all else): PC<=0, I_REQ<=0,
//   cnt<=0, ->IDLE; IR unchanged; no DONE/ERR pulse; coincident I_VALID dropped.
//  FETCH / PC_LD outside IDLE: ignored, no side effect. I_VALID while I_REQ=0:
//   ignored. PC_LD with BR_OFF=0: PC unchanged.
//  FETCH_DONE and FETCH_ERR never high together; BUSY = (state!=IDLE).
// TESTING
//  1 Reset: Reset=0 2 cycles, arbitrary inputs -> all outputs 0, IDLE.
//  2 Fetch: PC=0, FETCH, mem returns 16'h1234 with I_VALID 1 cycle after I_REQ ->
//    I_ADDR=0, IR=16'h1234, PC=1, FETCH_DONE one cycle, 3 cycles total.
//  3 Wrap/branch: PC=7'h7F fetch -> PC=0; PC=5, PC_LD BR_OFF=8'hFA -> PC=7'h7F;
//    PC=3, BR_OFF=8'h7F -> PC=7'h02 (truncation).
//  4 Timeout: FETCH, I_VALID never -> I_REQ high 15 cycles, FETCH_ERR pulse,
//    PC/IR unchanged; rerun with I_VALID on 15th cycle -> FETCH_DONE, no ERR.
//  5 Abort: PC_CLR mid-WAIT together with I_VALID -> PC=0, I_REQ=0 next cycle,
//    IR old value, no DONE/ERR; FETCH+PC_LD same cycle -> branch only, no I_REQ.
//  6 Reset mid-WAIT: Reset=0 while I_REQ=1 -> all outputs 0 next edge, no pulses.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// rtl/instruction_fetch_unit_if.sv - instruction-memory read handshake between fetch unit and memory
interface instruction_fetch_unit_if #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16
);
  logic [PC_W-1:0]    i_addr;
  logic               i_req;
  logic [INSTR_W-1:0] i_rdata;
  logic               i_valid;

  modport master (
    output i_addr,
    output i_req,
    input  i_rdata,
    input  i_valid
  );

  modport slave (
    input  i_addr,
    input  i_req,
    output i_rdata,
    output i_valid
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC/IR owner; fetches one instruction per FETCH over a req/valid handshake
module instruction_fetch_unit #(
  parameter int PC_W    = 7,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   fetch_i,
  input  logic                   pc_clr_i,
  input  logic                   pc_ld_i,
  input  logic [7:0]             br_off_i,
  instruction_fetch_unit_if.master imem,
  output logic [PC_W-1:0]        pc_o,
  output logic [INSTR_W-1:0]     ir_o,
  output logic                   busy_o,
  output logic                   fetch_done_o,
  output logic                   fetch_err_o
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [PC_W-1:0]    addr_q, addr_d;
  logic               req_q, req_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;

  logic [PC_W-1:0]    br_ext;
  logic [PC_W-1:0]    pc_br;
  logic [PC_W-1:0]    pc_inc;
  logic               timed_out;

  // Sign-extend (or truncate) the offset to PC width; the sum then wraps mod 2^PC_W.
  assign br_ext    = PC_W'($signed(br_off_i));
  assign pc_br     = pc_q + br_ext;
  assign pc_inc    = pc_q + PC_W'(1);
  assign timed_out = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      addr_q  <= '0;
      req_q   <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      addr_q  <= addr_d;
      req_q   <= req_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (pc_clr_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (fetch_i && !pc_ld_i) state_d = S_WAIT;
        S_WAIT: begin
          if (imem.i_valid)   state_d = S_DONE;
          else if (timed_out) state_d = S_IDLE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Datapath next-state; PC_CLR wins over everything but reset and drops any coincident valid.
  always_comb begin
    pc_d   = pc_q;
    ir_d   = ir_q;
    addr_d = addr_q;
    req_d  = req_q;
    cnt_d  = cnt_q;
    err_d  = 1'b0;
    if (pc_clr_i) begin
      pc_d  = '0;
      req_d = 1'b0;
      cnt_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pc_ld_i) begin
            pc_d = pc_br;
          end else if (fetch_i) begin
            addr_d = pc_q;
            req_d  = 1'b1;
            cnt_d  = '0;
          end
        end
        S_WAIT: begin
          if (imem.i_valid) begin
            ir_d  = imem.i_rdata;
            pc_d  = pc_inc;
            req_d = 1'b0;
          end else if (timed_out) begin
            req_d = 1'b0;
            err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy_o       = (state_q != S_IDLE);
    fetch_done_o = (state_q == S_DONE);
    fetch_err_o  = err_q;
    pc_o         = pc_q;
    ir_o         = ir_q;
    imem.i_addr  = addr_q;
    imem.i_req   = req_q;
  end

endmodule
